// File: rtl/nan_des_pipe.sv
// Per-lane 1->0 transition detector with a 2-stage valid/ready pipeline and active-low result.
// Optional saturating fall-event counter enabled by defining NAN_DES_PIPE_CNT_EN.
module nan_des_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_n,
  output logic [CNT_W-1:0] fall_cnt
);

  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] s1_inv_q, s1_inv_d;
  logic [WIDTH-1:0] s1_prev_q, s1_prev_d;
  logic [WIDTH-1:0] s2_d_q, s2_d_d;
  logic             s2_adv, s1_adv, in_acc;

  // Handshake decode and next-state for both pipeline stages
  always_comb begin
    s2_adv    = !s2_v_q || out_ready;
    s1_adv    = s1_v_q && s2_adv;
    in_ready  = !s1_v_q || s2_adv;
    in_acc    = in_valid && in_ready;

    s1_v_d    = s1_v_q;
    s1_inv_d  = s1_inv_q;
    s1_prev_d = s1_prev_q;
    prev_d    = prev_q;
    s2_v_d    = s2_v_q;
    s2_d_d    = s2_d_q;

    if (in_acc) begin
      s1_inv_d  = ~in_data;
      s1_prev_d = prev_q;
      prev_d    = in_data;
      s1_v_d    = 1'b1;
    end else if (s1_adv) begin
      s1_v_d    = 1'b0;
    end else begin
      s1_v_d    = s1_v_q;
    end

    if (s1_adv) begin
      s2_d_d = s1_inv_q & s1_prev_q;
      s2_v_d = 1'b1;
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end else begin
      s2_v_d = s2_v_q;
    end
  end

  // Pipeline state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      prev_q    <= {WIDTH{1'b0}};
      s1_inv_q  <= {WIDTH{1'b0}};
      s1_prev_q <= {WIDTH{1'b0}};
      s2_d_q    <= {WIDTH{1'b0}};
    end else begin
      s1_v_q    <= s1_v_d;
      s2_v_q    <= s2_v_d;
      prev_q    <= prev_d;
      s1_inv_q  <= s1_inv_d;
      s1_prev_q <= s1_prev_d;
      s2_d_q    <= s2_d_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_n     = ~s2_d_q;

`ifdef NAN_DES_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count delivered results carrying at least one fall; hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (s2_v_q && out_ready && (|s2_d_q) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Fall counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fall_cnt = cnt_q;
`else
  assign fall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_nan_des_pipe.sv
// Scoreboard bench for nan_des_pipe: expected out_n pushed on each accepted sample, popped on each output transfer.
// Counter checks follow NAN_DES_PIPE_CNT_EN (CNT_W=2 to reach saturation).
module tb_nan_des_pipe;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_n;
  logic [CW-1:0] fall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  sb[$];
  logic [W-1:0]  m_prev  = 8'h00;
  logic [CW-1:0] exp_cnt = 2'b00;
  logic [W-1:0]  e;

  nan_des_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .fall_cnt(fall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor at 1 time unit before each rising edge: pop/compare on output transfer, push model result on accept
  always @(negedge clk) begin
    #4;
    if (rst) begin
      sb.delete();
      m_prev  = 8'h00;
      exp_cnt = 2'b00;
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got out_n=%h, expected no output", out_n);
        end else begin
          e = sb.pop_front();
          if (out_n !== e) begin
            n_fail++;
            $display("FAIL sb_out_n: got %h, expected %h", out_n, e);
          end
          n_checks++;
          if (fall_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL sb_fall_cnt: got %0d, expected %0d", fall_cnt, exp_cnt);
          end
`ifdef NAN_DES_PIPE_CNT_EN
          if (e != 8'hFF && exp_cnt != 2'b11) exp_cnt = exp_cnt + 2'b01;
`endif
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(~(m_prev & ~in_data));
        m_prev = in_data;
      end
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk); #4;
      if (in_ready) begin
        @(posedge clk); #2;
        break;
      end
      n++;
      if (n > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
        @(posedge clk); #2;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_checks++; if (out_n !== 8'hFF) begin n_fail++; $display("FAIL reset_out_n: got %h, expected ff", out_n); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    n_checks++; if (fall_cnt !== 2'b00) begin n_fail++; $display("FAIL reset_fall_cnt: got %0d, expected 0", fall_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send(8'hFF);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: out_valid=%b, expected 0", out_valid); end
    @(posedge clk); #2;
    n_checks++; if (out_valid !== 1'b1 || out_n !== 8'hFF) begin n_fail++; $display("FAIL lat_first: out_valid=%b out_n=%h, expected 1 ff", out_valid, out_n); end
    send(8'h0F);
    @(posedge clk); #2;
    n_checks++; if (out_valid !== 1'b1 || out_n !== 8'h0F) begin n_fail++; $display("FAIL basic_fall: out_valid=%b out_n=%h, expected 1 0f", out_valid, out_n); end
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    send(8'hA5); send(8'h5A); send(8'hA5);
    n_checks++; if (out_valid !== 1'b1 || out_n !== 8'h5A) begin n_fail++; $display("FAIL b2b_second: out_valid=%b out_n=%h, expected 1 5a", out_valid, out_n); end
    @(posedge clk); #2;
    n_checks++; if (out_valid !== 1'b1 || out_n !== 8'hA5) begin n_fail++; $display("FAIL b2b_third: out_valid=%b out_n=%h, expected 1 a5", out_valid, out_n); end
    drain();
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    send(8'h3C); send(8'hC3);
    in_valid = 1'b1; in_data = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #4;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, expected 0", in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_n !== 8'hFF) begin n_fail++; $display("FAIL stall_hold: out_valid=%b out_n=%h, expected 1 ff", out_valid, out_n); end
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    send(8'h0F); send(8'hF0);
    drain();
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    send(8'hAA); send(8'h55);
    @(negedge clk); #4;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b, expected 0", in_ready); end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready); end
    n_checks++; if (out_n !== 8'hFF || fall_cnt !== 2'b00) begin n_fail++; $display("FAIL midrst_out: out_n=%h fall_cnt=%0d, expected ff 0", out_n, fall_cnt); end
    out_ready = 1'b1;
    send(8'h00);
    @(posedge clk); #2;
    n_checks++; if (out_valid !== 1'b1 || out_n !== 8'hFF) begin n_fail++; $display("FAIL midrst_prev: out_valid=%b out_n=%h, expected 1 ff", out_valid, out_n); end
    drain();
  endtask

  task automatic test_fall_cnt();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(8'hFF); send(8'h00);
    end
    drain();
    @(posedge clk); #2;
    n_checks++; if (fall_cnt !== exp_cnt) begin n_fail++; $display("FAIL cnt_final: got %0d, expected %0d", fall_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_fall_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
